// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the system-bus arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_WAIT_START,
        ARB_OWN
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

    localparam int START_WINDOW_DEF = 4;
    localparam int WDOG_CYCLES_DEF  = 1024;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - loadable saturating down-counter shared by start window and watchdog
module arb_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - icache/dcache round-robin bus arbiter; optional OWN watchdog via ARB_WATCHDOG_EN
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int START_WINDOW = START_WINDOW_DEF,
    parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       icache_busreq,
    input  logic       icache_busidle,
    output logic       icache_busgrant,
    input  logic       dcache_busreq,
    input  logic       dcache_busidle,
    output logic       dcache_busgrant,
    output logic [1:0] bus_owner,
    output logic       arb_wdog_err
);

    localparam int TW = $clog2(max2(START_WINDOW, WDOG_CYCLES) + 1);

    arb_state_t    state, state_n;
    owner_t        owner, owner_n;
    owner_t        last_owner, last_n;
    logic          t_load, t_dec, t_zero;
    logic [TW-1:0] t_val, t_count;
    logic          own_idle, timer_last;
`ifdef ARB_WATCHDOG_EN
    logic          wdog_trip;
`endif

    arb_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero),
        .count    (t_count)
    );

    // Only the owner's busidle matters; the other cache is ignored.
    assign own_idle   = (owner == OWN_I) ? icache_busidle : dcache_busidle;
    assign timer_last = t_zero || (t_count == TW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_D;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = TW'(START_WINDOW);
`ifdef ARB_WATCHDOG_EN
        wdog_trip = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                if (icache_busreq && dcache_busreq) begin
                    owner_n = (last_owner == OWN_I) ? OWN_D : OWN_I;
                    state_n = ARB_GRANT;
                end else if (icache_busreq) begin
                    owner_n = OWN_I;
                    state_n = ARB_GRANT;
                end else if (dcache_busreq) begin
                    owner_n = OWN_D;
                    state_n = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                t_load  = 1'b1;
                state_n = ARB_WAIT_START;
            end
            ARB_WAIT_START: begin
                t_dec = 1'b1;
                if (!own_idle) begin
                    state_n = ARB_OWN;
                    last_n  = owner;
`ifdef ARB_WATCHDOG_EN
                    t_load  = 1'b1;
                    t_val   = TW'(WDOG_CYCLES);
`endif
                end else if (timer_last) begin
                    state_n = ARB_IDLE;
                    owner_n = OWN_NONE;
                end
            end
            ARB_OWN: begin
                if (own_idle) begin
                    state_n = ARB_IDLE;
                    owner_n = OWN_NONE;
                end
`ifdef ARB_WATCHDOG_EN
                else begin
                    t_dec = 1'b1;
                    if (timer_last) begin
                        state_n   = ARB_IDLE;
                        owner_n   = OWN_NONE;
                        wdog_trip = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_n = ARB_IDLE;
                owner_n = OWN_NONE;
            end
        endcase
    end

    // Outputs are registered copies of the next state/owner, so they track the FSM flops exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            icache_busgrant <= 1'b0;
            dcache_busgrant <= 1'b0;
            bus_owner       <= 2'b00;
        end else begin
            icache_busgrant <= (state_n == ARB_GRANT) && (owner_n == OWN_I);
            dcache_busgrant <= (state_n == ARB_GRANT) && (owner_n == OWN_D);
            bus_owner       <= owner_n;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            arb_wdog_err <= 1'b0;
        end else if (wdog_trip) begin
            arb_wdog_err <= 1'b1;
        end
    end
`else
    assign arb_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with a cycle-level reference model
module tb_mem_bus_arbiter;

    localparam int SW = 4;
    localparam int WD = 16;
`ifdef ARB_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       icache_busreq = 1'b0, icache_busidle = 1'b1;
    logic       dcache_busreq = 1'b0, dcache_busidle = 1'b1;
    logic       icache_busgrant, dcache_busgrant, arb_wdog_err;
    logic [1:0] bus_owner;

    int n_cmp = 0;
    int n_bad = 0;

    // model: owner 0 none / 1 icache / 2 dcache; age 0 is the grant cycle, 1..SW the start window
    int m_own = 0, m_age = 0, m_ocnt = 0, m_last = 2;
    bit m_started = 0, m_err = 0;

    mem_bus_arbiter #(.START_WINDOW(SW), .WDOG_CYCLES(WD)) dut (
        .clk             (clk),
        .reset           (reset),
        .icache_busreq   (icache_busreq),
        .icache_busidle  (icache_busidle),
        .icache_busgrant (icache_busgrant),
        .dcache_busreq   (dcache_busreq),
        .dcache_busidle  (dcache_busidle),
        .dcache_busgrant (dcache_busgrant),
        .bus_owner       (bus_owner),
        .arb_wdog_err    (arb_wdog_err)
    );

    always #5 clk = ~clk;

    wire [4:0] dut_vec = {icache_busgrant, dcache_busgrant, bus_owner, arb_wdog_err};

    function automatic logic [4:0] exp_vec();
        logic gi, gd;
        logic [1:0] own;
        gi  = (m_own == 1) && (m_age == 0);
        gd  = (m_own == 2) && (m_age == 0);
        own = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        return {gi, gd, own, m_err};
    endfunction

    task automatic tick();
        logic ri, rd, oi;
        ri = icache_busreq;
        rd = dcache_busreq;
        oi = (m_own == 1) ? icache_busidle : dcache_busidle;
        @(posedge clk);
        if (reset) begin
            m_own = 0; m_age = 0; m_ocnt = 0; m_last = 2; m_started = 0; m_err = 0;
        end else if (m_own == 0) begin
            if (ri && rd) m_own = (m_last == 2) ? 1 : 2;
            else if (ri)  m_own = 1;
            else if (rd)  m_own = 2;
            m_age = 0;
            m_started = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!m_started) begin
            if (!oi) begin
                m_started = 1; m_last = m_own; m_ocnt = 0;
            end else if (m_age == SW) begin
                m_own = 0;
            end else begin
                m_age++;
            end
        end else begin
            m_ocnt++;
            if (oi) m_own = 0;
            else if (WDOG_EN && m_ocnt == WD) begin
                m_own = 0; m_err = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        icache_busreq = 0; dcache_busreq = 0; icache_busidle = 1; dcache_busidle = 1;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        icache_busreq = 1; dcache_busreq = 1;
        reset = 1;
        tick();
        n_cmp++;
        if (dut_vec !== 5'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want %b", dut_vec, 5'b0);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_model: got %b want %b", dut_vec, exp_vec());
        end
        do_reset();
    endtask

    task automatic test_icache_only();
        do_reset();
        icache_busreq = 1;
        tick();
        n_cmp++;
        if ({icache_busgrant, dcache_busgrant, bus_owner} !== 4'b1001) begin
            n_bad++; $display("FAIL icache_grant: got %b want 1001", {icache_busgrant, dcache_busgrant, bus_owner});
        end
        icache_busreq = 0;
        tick();
        n_cmp++;
        if ({icache_busgrant, bus_owner} !== 3'b001) begin
            n_bad++; $display("FAIL icache_grant_pulse: got %b want 001", {icache_busgrant, bus_owner});
        end
        icache_busidle = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== 5'b00010) begin
                n_bad++; $display("FAIL icache_own[%0d]: got %b want 00010", i, dut_vec);
            end
        end
        icache_busidle = 1;
        tick();
        n_cmp++;
        if (bus_owner !== 2'b00) begin
            n_bad++; $display("FAIL icache_release: got %b want 00", bus_owner);
        end
    endtask

    task automatic test_tie();
        do_reset();
        icache_busreq = 1; dcache_busreq = 1;
        tick();
        n_cmp++;
        if ({icache_busgrant, dcache_busgrant} !== 2'b10) begin
            n_bad++; $display("FAIL tie_first: got %b want 10", {icache_busgrant, dcache_busgrant});
        end
        icache_busreq = 0;
        tick();
        icache_busidle = 0;
        tick();
        tick();
        icache_busidle = 1;
        tick();
        n_cmp++;
        if ({dcache_busgrant, bus_owner} !== 3'b000) begin
            n_bad++; $display("FAIL tie_dead_cycle: got %b want 000", {dcache_busgrant, bus_owner});
        end
        tick();
        n_cmp++;
        if ({icache_busgrant, dcache_busgrant, bus_owner} !== 4'b0110) begin
            n_bad++; $display("FAIL tie_second: got %b want 0110", {icache_busgrant, dcache_busgrant, bus_owner});
        end
        dcache_busreq = 0;
        tick();
        dcache_busidle = 0;
        tick();
        dcache_busidle = 1;
        tick();
        icache_busreq = 1; dcache_busreq = 1;
        tick();
        n_cmp++;
        if ({icache_busgrant, dcache_busgrant} !== 2'b10) begin
            n_bad++; $display("FAIL tie_rr_again: got %b want 10", {icache_busgrant, dcache_busgrant});
        end
    endtask

    task automatic test_no_start();
        int cnt;
        do_reset();
        icache_busreq = 1;
        tick();
        icache_busreq = 0;
        tick();
        icache_busidle = 0;
        tick();
        icache_busidle = 1;
        tick();
        dcache_busreq = 1;
        tick();
        dcache_busreq = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_owner == 2'b10) cnt++;
        end
        n_cmp++;
        if (cnt !== SW) begin
            n_bad++; $display("FAIL no_start_window: got %0d cycles want %0d", cnt, SW);
        end
        n_cmp++;
        if (arb_wdog_err !== 1'b0) begin
            n_bad++; $display("FAIL no_start_err: got %b want 0", arb_wdog_err);
        end
        icache_busreq = 1; dcache_busreq = 1;
        tick();
        n_cmp++;
        if ({icache_busgrant, dcache_busgrant} !== 2'b01) begin
            n_bad++; $display("FAIL no_start_last_owner: got %b want 01", {icache_busgrant, dcache_busgrant});
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        icache_busreq = 1;
        tick();
        icache_busreq = 0;
        tick();
        icache_busidle = 0;
        tick();
        tick();
        icache_busreq = 1;
        reset = 1;
        tick();
        n_cmp++;
        if (dut_vec !== 5'b0) begin
            n_bad++; $display("FAIL reset_mid: got %b want %b", dut_vec, 5'b0);
        end
        reset = 0;
        icache_busidle = 1;
        tick();
        n_cmp++;
        if ({icache_busgrant, dcache_busgrant, bus_owner} !== 4'b1001) begin
            n_bad++; $display("FAIL reset_mid_regrant: got %b want 1001", {icache_busgrant, dcache_busgrant, bus_owner});
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        dcache_busreq = 1;
        tick();
        dcache_busreq = 0;
        tick();
        dcache_busidle = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL wdog_cycle[%0d]: got %b want %b", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if ({bus_owner, arb_wdog_err} !== (WDOG_EN ? 3'b001 : 3'b100)) begin
            n_bad++; $display("FAIL wdog_end: got %b want %b", {bus_owner, arb_wdog_err}, (WDOG_EN ? 3'b001 : 3'b100));
        end
        dcache_busidle = 1;
    endtask

    task automatic test_random();
        logic req[2], idl[2], gnt;
        int   dly[2], len[2];
        do_reset();
        for (int c = 0; c < 2; c++) begin
            req[c] = 0; idl[c] = 1; dly[c] = -1; len[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random[%0d]: got %b want %b", cyc, dut_vec, exp_vec());
            end
            for (int c = 0; c < 2; c++) begin
                gnt = (c == 0) ? icache_busgrant : dcache_busgrant;
                if (gnt) begin
                    req[c] = 0;
                    dly[c] = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 5)) : -1;
                end else if (dly[c] > 0) begin
                    dly[c]--;
                end else if (dly[c] == 0) begin
                    idl[c] = 0; len[c] = $urandom_range(1, 8); dly[c] = -1;
                end else if (!idl[c]) begin
                    len[c]--;
                    if (len[c] == 0) idl[c] = 1;
                end else if (!req[c] && $urandom_range(0, 3) == 0) begin
                    req[c] = 1;
                end
            end
            icache_busreq = req[0]; icache_busidle = idl[0];
            dcache_busreq = req[1]; dcache_busidle = idl[1];
        end
    endtask

    initial begin
        test_reset();
        test_icache_only();
        test_tie();
        test_no_start();
        test_reset_mid_burst();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
